mam_pkt_req: RTL and testbench

Front-end request generator for the memory access module (MAM). It parses a 16-bit word stream of MAM access packets (header, address, write data) and drives the MAM Wishbone interface's request/write/read handshake ports. Read data returned by that interface is serialized back into a 16-bit output stream. It sits directly upstream of `mam_wb_if`, between the debug packet interface and the bus master.

---
 rtl/mam_pkt_req_pkg.sv | 20 ++
 rtl/mam_pkt_req_word_ser.sv | 58 +++++
 rtl/mam_pkt_req.sv | 202 ++++++++++++++++++++
 tb/tb_mam_pkt_req.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mam_pkt_req_pkg.sv
// Shared definitions for the MAM packet request generator.
//   RW_BIT / BURST_BIT / BEATS_MSB : header word field positions
//   state_e                        : request generator FSM states
package mam_pkg;

  localparam int RW_BIT    = 15;
  localparam int BURST_BIT = 14;
  localparam int BEATS_MSB = 13;

  typedef enum logic [2:0] {
    S_HDR,
    S_ADDR,
    S_REQ,
    S_WCOL,
    S_WPUSH,
    S_RWAIT,
    S_RSER
  } state_e;

endpackage

// File: rtl/mam_pkt_req_word_ser.sv
// W-word shift register used both to collect write words into a beat and to
// serialize a read beat into 16-bit words, MSB word first.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_data_i and restart the word count
//   load_data_i   : parallel beat to load
//   shift_i       : shift one word toward the MSB end, shift_in_i enters at LSB
//   shift_in_i    : word entering at the LSB end
//   data_o        : current register contents
//   last_o        : word count is at the W-th word of the beat
module mam_word_ser #(
  parameter int W = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [16*W-1:0] load_data_i,
  input  logic            shift_i,
  input  logic [15:0]     shift_in_i,
  output logic [16*W-1:0] data_o,
  output logic            last_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [16*W-1:0] data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [16*W+15:0] shifted;

  assign last_o = (cnt_q == CW'(W - 1));
  assign data_o = data_q;

  // The concatenation keeps the shift legal for W=1, where there is no
  // remaining upper part to move.
  assign shifted = {data_q, shift_in_i};

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = load_data_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      data_d = shifted[16*W-1:0];
      cnt_d  = last_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mam_pkt_req.sv
// MAM packet front end: parses a 16-bit packet word stream (header, address,
// write data) into mam_wb_if request/write handshakes and serializes returned
// read beats back into a 16-bit word stream.
//   CLK_I, RST_NI                       : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready           : packet word input stream
//   out_data/out_valid/out_last/out_ready : read data output stream
//   req_*                               : request to mam_wb_if
//   write_*                             : write beat handshake
//   read_*                              : read beat handshake
//   err                                 : pulse when a zero-beat burst header is dropped
module mam_pkt_req
  import mam_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    CLK_I,
  input  logic                    RST_NI,
  input  logic [15:0]             in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [15:0]             out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_rw,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    req_burst,
  output logic [13:0]             req_beats,
  output logic                    write_valid,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH/8-1:0] write_strb,
  input  logic                    write_ready,
  input  logic                    read_valid,
  input  logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_ready,
  output logic                    err
);

  localparam int W   = DATA_WIDTH / 16;
  localparam int A   = ADDR_WIDTH / 16;
  localparam int SW  = DATA_WIDTH / 8;
  localparam int ACW = (A > 1) ? $clog2(A) : 1;

  state_e                state_q, state_d;
  logic                  rw_q, rw_d;
  logic                  burst_q, burst_d;
  logic [13:0]           beats_q, beats_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ACW-1:0]        acnt_q, acnt_d;
  logic [13:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  wr_shift, wr_last;
  logic                  rd_load, rd_shift, rd_last;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH+15:0] addr_shifted;

  assign addr_shifted = {addr_q, in_data};

  // Next-state and datapath control. Every handshake is qualified only by the
  // partner's valid/ready because our own side is decoded from state_q.
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    burst_d  = burst_q;
    beats_d  = beats_q;
    strb_d   = strb_q;
    addr_d   = addr_q;
    acnt_d   = acnt_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    wr_shift = 1'b0;
    rd_load  = 1'b0;
    rd_shift = 1'b0;
    case (state_q)
      S_HDR: begin
        if (in_valid) begin
          rw_d    = in_data[RW_BIT];
          burst_d = in_data[BURST_BIT];
          if (in_data[BURST_BIT]) begin
            beats_d = in_data[BEATS_MSB:0];
            strb_d  = '1;
          end else begin
            beats_d = 14'd1;
            strb_d  = in_data[SW-1:0];
          end
          cnt_d  = beats_d;
          acnt_d = '0;
          if (in_data[BURST_BIT] && (in_data[BEATS_MSB:0] == 14'd0)) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (in_valid) begin
          addr_d = addr_shifted[ADDR_WIDTH-1:0];
          if (acnt_q == ACW'(A - 1)) begin
            state_d = S_REQ;
          end else begin
            acnt_d = acnt_q + ACW'(1);
          end
        end
      end
      S_REQ: begin
        if (req_ready) state_d = rw_q ? S_WCOL : S_RWAIT;
      end
      S_WCOL: begin
        if (in_valid) begin
          wr_shift = 1'b1;
          if (wr_last) state_d = S_WPUSH;
        end
      end
      S_WPUSH: begin
        if (write_ready) begin
          if (cnt_q != 14'd0) cnt_d = cnt_q - 14'd1;
          state_d = (cnt_q <= 14'd1) ? S_HDR : S_WCOL;
        end
      end
      S_RWAIT: begin
        if (read_valid) begin
          rd_load = 1'b1;
          if (cnt_q != 14'd0) cnt_d = cnt_q - 14'd1;
          state_d = S_RSER;
        end
      end
      S_RSER: begin
        if (out_ready) begin
          rd_shift = 1'b1;
          if (rd_last) state_d = (cnt_q == 14'd0) ? S_HDR : S_RWAIT;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= S_HDR;
      rw_q    <= 1'b0;
      burst_q <= 1'b0;
      beats_q <= '0;
      strb_q  <= '0;
      addr_q  <= '0;
      acnt_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      burst_q <= burst_d;
      beats_q <= beats_d;
      strb_q  <= strb_d;
      addr_q  <= addr_d;
      acnt_q  <= acnt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  mam_word_ser #(.W(W)) u_wr_ser (
    .clk_i       (CLK_I),
    .rst_ni      (RST_NI),
    .load_i      (1'b0),
    .load_data_i ({DATA_WIDTH{1'b0}}),
    .shift_i     (wr_shift),
    .shift_in_i  (in_data),
    .data_o      (write_data),
    .last_o      (wr_last)
  );

  mam_word_ser #(.W(W)) u_rd_ser (
    .clk_i       (CLK_I),
    .rst_ni      (RST_NI),
    .load_i      (rd_load),
    .load_data_i (read_data),
    .shift_i     (rd_shift),
    .shift_in_i  (16'h0000),
    .data_o      (rd_data),
    .last_o      (rd_last)
  );

  assign in_ready    = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_WCOL);
  assign req_valid   = (state_q == S_REQ);
  assign write_valid = (state_q == S_WPUSH);
  assign read_ready  = (state_q == S_RWAIT);
  assign out_valid   = (state_q == S_RSER);
  assign out_last    = (state_q == S_RSER) && rd_last && (cnt_q == 14'd0);
  assign out_data    = rd_data[DATA_WIDTH-1 -: 16];
  assign req_rw      = rw_q;
  assign req_burst   = burst_q;
  assign req_beats   = beats_q;
  assign req_addr    = addr_q;
  assign write_strb  = strb_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mam_pkt_req.sv
// Directed bench for mam_pkt_req with DATA_WIDTH=32, ADDR_WIDTH=32.
module tb_mam_pkt_req;

  logic        CLK_I = 1'b0;
  logic        RST_NI = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_rw, req_burst;
  logic [31:0] req_addr;
  logic [13:0] req_beats;
  logic        write_valid;
  logic [31:0] write_data;
  logic [3:0]  write_strb;
  logic        write_ready = 1'b0;
  logic        read_valid = 1'b0;
  logic [31:0] read_data = '0;
  logic        read_ready;
  logic        err;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 CLK_I = ~CLK_I;

  mam_pkt_req #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
    .req_burst(req_burst), .req_beats(req_beats),
    .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb),
    .write_ready(write_ready),
    .read_valid(read_valid), .read_data(read_data), .read_ready(read_ready),
    .err(err)
  );

  function automatic logic sel_sig(input int sel);
    case (sel)
      0: return req_valid;
      1: return write_valid;
      2: return read_ready;
      3: return out_valid;
      default: return in_ready;
    endcase
  endfunction

  // Bounded wait at negedges until the selected DUT output is high.
  task automatic wait_high(input int sel, input string name);
    int n = 0;
    while (!sel_sig(sel) && n < 50) begin
      @(negedge CLK_I);
      n++;
    end
    if (n >= 50) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL timeout_%s got 0 want 1", name);
    end
  endtask

  // All stimulus tasks start and end at a negedge.
  task automatic send_word(input logic [15:0] w);
    in_data  = w;
    in_valid = 1'b1;
    wait_high(4, "in_ready");
    @(posedge CLK_I);
    #1 in_valid = 1'b0;
    @(negedge CLK_I);
  endtask

  task automatic accept_req();
    wait_high(0, "req_valid");
    req_ready = 1'b1;
    @(posedge CLK_I);
    #1 req_ready = 1'b0;
    @(negedge CLK_I);
  endtask

  task automatic accept_write();
    wait_high(1, "write_valid");
    write_ready = 1'b1;
    @(posedge CLK_I);
    #1 write_ready = 1'b0;
    @(negedge CLK_I);
  endtask

  task automatic give_read(input logic [31:0] d);
    wait_high(2, "read_ready");
    read_valid = 1'b1;
    read_data  = d;
    @(posedge CLK_I);
    #1 read_valid = 1'b0;
    @(negedge CLK_I);
  endtask

  task automatic take_word();
    out_ready = 1'b1;
    @(posedge CLK_I);
    #1 out_ready = 1'b0;
    @(negedge CLK_I);
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    @(negedge CLK_I);
    outs = {req_valid, write_valid, read_ready, out_valid, out_last, err, 2'b00};
    testsRun++; if (outs !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_flags got %h want 00", outs); end
    testsRun++; if (req_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_addr got %h want 00000000", req_addr); end
    testsRun++; if (write_data !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_wdata got %h want 00000000", write_data); end
    RST_NI = 1'b1;
    @(negedge CLK_I);
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_write();
    send_word(16'h800F);
    send_word(16'h0000);
    send_word(16'h1000);
    testsRun++; if (req_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL sw_req_valid got %b want 1", req_valid); end
    testsRun++; if ({req_rw, req_burst} !== 2'b10) begin testsFailed++; $display("[TB] FAIL sw_rw_burst got %b want 10", {req_rw, req_burst}); end
    testsRun++; if (req_addr !== 32'h0000_1000) begin testsFailed++; $display("[TB] FAIL sw_addr got %h want 00001000", req_addr); end
    testsRun++; if (req_beats !== 14'd1) begin testsFailed++; $display("[TB] FAIL sw_beats got %0d want 1", req_beats); end
    accept_req();
    send_word(16'hDEAD);
    testsRun++; if (write_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL sw_wvalid_early got %b want 0", write_valid); end
    send_word(16'hBEEF);
    testsRun++; if (write_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL sw_wvalid got %b want 1", write_valid); end
    testsRun++; if (write_data !== 32'hDEAD_BEEF) begin testsFailed++; $display("[TB] FAIL sw_wdata got %h want deadbeef", write_data); end
    testsRun++; if (write_strb !== 4'hF) begin testsFailed++; $display("[TB] FAIL sw_strb got %h want f", write_strb); end
    accept_write();
    testsRun++; if ({in_ready, write_valid, req_valid} !== 3'b100) begin testsFailed++; $display("[TB] FAIL sw_idle got %b want 100", {in_ready, write_valid, req_valid}); end
  endtask

  task automatic test_burst_read();
    logic [31:0] beats [3];
    logic [15:0] exp_w [6];
    beats = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    send_word(16'h4003);
    send_word(16'h0000);
    send_word(16'h0040);
    testsRun++; if ({req_valid, req_rw, req_burst} !== 3'b101) begin testsFailed++; $display("[TB] FAIL br_req got %b want 101", {req_valid, req_rw, req_burst}); end
    testsRun++; if (req_beats !== 14'd3) begin testsFailed++; $display("[TB] FAIL br_beats got %0d want 3", req_beats); end
    testsRun++; if (req_addr !== 32'h0000_0040) begin testsFailed++; $display("[TB] FAIL br_addr got %h want 00000040", req_addr); end
    accept_req();
    for (int b = 0; b < 3; b++) begin
      give_read(beats[b]);
      for (int k = 0; k < 2; k++) begin
        testsRun++; if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL br_ovalid%0d got %b want 1", 2*b+k, out_valid); end
        testsRun++; if (out_data !== exp_w[2*b+k]) begin testsFailed++; $display("[TB] FAIL br_odata%0d got %h want %h", 2*b+k, out_data, exp_w[2*b+k]); end
        testsRun++; if (out_last !== ((2*b+k) == 5)) begin testsFailed++; $display("[TB] FAIL br_olast%0d got %b want %b", 2*b+k, out_last, (2*b+k) == 5); end
        testsRun++; if (read_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL br_rready%0d got %b want 0", 2*b+k, read_ready); end
        take_word();
      end
    end
    testsRun++; if ({in_ready, out_valid} !== 2'b10) begin testsFailed++; $display("[TB] FAIL br_idle got %b want 10", {in_ready, out_valid}); end
  endtask

  task automatic test_out_backpressure();
    send_word(16'h4002);
    send_word(16'h0000);
    send_word(16'h0050);
    accept_req();
    give_read(32'h1111_2222);
    take_word();
    take_word();
    give_read(32'h3333_4444);
    for (int c = 0; c < 5; c++) begin
      testsRun++; if (out_data !== 16'h3333) begin testsFailed++; $display("[TB] FAIL bp_odata%0d got %h want 3333", c, out_data); end
      testsRun++; if ({out_valid, read_ready} !== 2'b10) begin testsFailed++; $display("[TB] FAIL bp_hs%0d got %b want 10", c, {out_valid, read_ready}); end
      @(negedge CLK_I);
    end
    take_word();
    testsRun++; if ({out_data, out_last} !== {16'h4444, 1'b1}) begin testsFailed++; $display("[TB] FAIL bp_last got %h/%b want 4444/1", out_data, out_last); end
    take_word();
    testsRun++; if ({in_ready, out_valid, read_ready} !== 3'b100) begin testsFailed++; $display("[TB] FAIL bp_idle got %b want 100", {in_ready, out_valid, read_ready}); end
  endtask

  task automatic test_write_backpressure();
    send_word(16'hC002);
    send_word(16'h0000);
    send_word(16'h0200);
    testsRun++; if ({req_rw, req_burst, req_beats} !== {2'b11, 14'd2}) begin testsFailed++; $display("[TB] FAIL wb_req got %b/%0d want 11/2", {req_rw, req_burst}, req_beats); end
    accept_req();
    send_word(16'hA1A1);
    send_word(16'hB1B1);
    for (int c = 0; c < 4; c++) begin
      testsRun++; if ({write_valid, in_ready} !== 2'b10) begin testsFailed++; $display("[TB] FAIL wb_hs%0d got %b want 10", c, {write_valid, in_ready}); end
      testsRun++; if ({write_data, write_strb} !== {32'hA1A1_B1B1, 4'hF}) begin testsFailed++; $display("[TB] FAIL wb_data%0d got %h/%h want a1a1b1b1/f", c, write_data, write_strb); end
      @(negedge CLK_I);
    end
    accept_write();
    testsRun++; if ({write_valid, in_ready} !== 2'b01) begin testsFailed++; $display("[TB] FAIL wb_next got %b want 01", {write_valid, in_ready}); end
    send_word(16'hC2C2);
    send_word(16'hD2D2);
    testsRun++; if (write_data !== 32'hC2C2_D2D2) begin testsFailed++; $display("[TB] FAIL wb_beat2 got %h want c2c2d2d2", write_data); end
    accept_write();
    testsRun++; if ({write_valid, in_ready, req_valid} !== 3'b010) begin testsFailed++; $display("[TB] FAIL wb_idle got %b want 010", {write_valid, in_ready, req_valid}); end
  endtask

  task automatic test_malformed();
    send_word(16'hC000);
    testsRun++; if ({err, req_valid} !== 2'b10) begin testsFailed++; $display("[TB] FAIL mf_err got %b want 10", {err, req_valid}); end
    @(negedge CLK_I);
    testsRun++; if ({err, req_valid, in_ready} !== 3'b001) begin testsFailed++; $display("[TB] FAIL mf_after got %b want 001", {err, req_valid, in_ready}); end
    send_word(16'h0003);
    send_word(16'h0000);
    send_word(16'h0080);
    testsRun++; if ({req_valid, req_rw, req_burst} !== 3'b100) begin testsFailed++; $display("[TB] FAIL mf_req got %b want 100", {req_valid, req_rw, req_burst}); end
    testsRun++; if ({req_addr, req_beats} !== {32'h0000_0080, 14'd1}) begin testsFailed++; $display("[TB] FAIL mf_addr got %h/%0d want 00000080/1", req_addr, req_beats); end
    testsRun++; if (write_strb !== 4'h3) begin testsFailed++; $display("[TB] FAIL mf_strb got %h want 3", write_strb); end
    accept_req();
    give_read(32'hCAFE_F00D);
    testsRun++; if ({out_data, out_last} !== {16'hCAFE, 1'b0}) begin testsFailed++; $display("[TB] FAIL mf_w0 got %h/%b want cafe/0", out_data, out_last); end
    take_word();
    testsRun++; if ({out_data, out_last} !== {16'hF00D, 1'b1}) begin testsFailed++; $display("[TB] FAIL mf_w1 got %h/%b want f00d/1", out_data, out_last); end
    take_word();
    testsRun++; if ({in_ready, out_valid} !== 2'b10) begin testsFailed++; $display("[TB] FAIL mf_idle got %b want 10", {in_ready, out_valid}); end
  endtask

  task automatic test_reset_mid_burst();
    logic [5:0] flags;
    send_word(16'hC002);
    send_word(16'h0000);
    send_word(16'h0300);
    accept_req();
    send_word(16'h1234);
    send_word(16'h5678);
    accept_write();
    send_word(16'h9ABC);
    RST_NI = 1'b0;
    #1;
    flags = {req_valid, write_valid, read_ready, out_valid, out_last, err};
    testsRun++; if (flags !== 6'b0) begin testsFailed++; $display("[TB] FAIL rm_flags got %b want 000000", flags); end
    testsRun++; if ({req_addr, write_data} !== 64'h0) begin testsFailed++; $display("[TB] FAIL rm_regs got %h/%h want 0/0", req_addr, write_data); end
    @(negedge CLK_I);
    RST_NI = 1'b1;
    @(negedge CLK_I);
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rm_in_ready got %b want 1", in_ready); end
    send_word(16'h0003);
    send_word(16'h0000);
    send_word(16'h0010);
    testsRun++; if ({req_valid, req_rw, req_addr} !== {2'b10, 32'h0000_0010}) begin testsFailed++; $display("[TB] FAIL rm_req got %b/%h want 10/00000010", {req_valid, req_rw}, req_addr); end
    accept_req();
    give_read(32'h0BAD_0001);
    take_word();
    testsRun++; if ({out_data, out_last} !== {16'h0001, 1'b1}) begin testsFailed++; $display("[TB] FAIL rm_read got %h/%b want 0001/1", out_data, out_last); end
    take_word();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_read();
    test_out_backpressure();
    test_write_backpressure();
    test_malformed();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
